// File: rtl/vol_step_ctrl.sv
// Volume button controller: turns vol-/vol+ presses into a saturating level with
// hold-to-repeat, and pushes every new level to the config path over a req/ack channel.
module vol_step_ctrl #(
  parameter int VOL_W         = 4,
  parameter int VOL_MAX       = 15,
  parameter int VOL_DEFAULT   = 8,
  parameter int HOLD_DELAY    = 12500000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_minus,
  input  logic             i_btn_plus,
  output logic [VOL_W-1:0] o_vol,
  output logic             o_wr_req,
  output logic [7:0]       o_wr_data,
  input  logic             i_wr_ack,
  output logic             o_busy,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [VOL_W-1:0] VOL_TOP   = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] VOL_RST   = VOL_W'(VOL_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic             pending_q, pending_d;
  logic             req_q, req_d;
  logic [7:0]       data_q, data_d;

  logic plus_p, minus_p, held_p, other_p;
  logic step_en, step_up, vol_changed;

  // Handshake: o_wr_req rises with o_wr_data already valid, both hold steady until
  // the cycle i_wr_ack is sampled high, and req then drops for at least one cycle.
  // i_wr_ack seen while o_wr_req is low has no effect.
  always_comb begin
    plus_p    = ~i_btn_plus;
    minus_p   = ~i_btn_minus;
    held_p    = dir_q ? plus_p  : minus_p;
    other_p   = dir_q ? minus_p : plus_p;
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    step_en   = 1'b0;
    step_up   = dir_q;

    case (state_q)
      ST_IDLE: begin
        if (plus_p && minus_p) begin
          state_d = ST_LOCK;
        end else if (plus_p || minus_p) begin
          step_en = 1'b1;
          step_up = plus_p;
          dir_d   = plus_p;
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!held_p) begin
          state_d = ST_IDLE;
        end else if (other_p) begin
          state_d = ST_LOCK;
        end else if (cnt_q == '0) begin
          step_en = 1'b1;
          cnt_d   = REP_LOAD;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (!plus_p && !minus_p) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    vol_d = vol_q;
    if (step_en) begin
      if (step_up && (vol_q != VOL_TOP))       vol_d = vol_q + VOL_W'(1);
      else if (!step_up && (vol_q != '0))      vol_d = vol_q - VOL_W'(1);
    end
    vol_changed = (vol_d != vol_q);

    // A change that lands while a request is in flight only marks pending, so
    // intermediate levels collapse into one follow-up write.
    req_d     = req_q;
    data_d    = data_q;
    pending_d = pending_q | vol_changed;
    if (req_q) begin
      if (i_wr_ack) req_d = 1'b0;
    end else if (pending_q) begin
      req_d     = 1'b1;
      data_d    = 8'(vol_q);
      pending_d = vol_changed;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      vol_q     <= VOL_RST;
      pending_q <= 1'b1;
      req_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      vol_q     <= vol_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      data_q    <= data_d;
    end
  end

  assign o_vol       = vol_q;
  assign o_wr_req    = req_q;
  assign o_wr_data   = data_q;
  assign o_busy      = req_q | pending_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_vol_step_ctrl.sv
// Bench for vol_step_ctrl: directed test-plan steps plus a random phase, checked each
// cycle against a hold-time based reference model and a write-data scoreboard.
module tb_vol_step_ctrl;

  localparam int VOL_W = 4;
  localparam int VMAX  = 15;
  localparam int VDEF  = 8;
  localparam int HOLD  = 10;
  localparam int REP   = 4;

  logic             i_clk;
  logic             i_rst;
  logic             i_btn_minus;
  logic             i_btn_plus;
  logic [VOL_W-1:0] o_vol;
  logic             o_wr_req;
  logic [7:0]       o_wr_data;
  logic             i_wr_ack;
  logic             o_busy;
  logic [1:0]       o_dbg_state;

  vol_step_ctrl #(
    .VOL_W(VOL_W), .VOL_MAX(VMAX), .VOL_DEFAULT(VDEF),
    .HOLD_DELAY(HOLD), .REPEAT_PERIOD(REP)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn_minus(i_btn_minus), .i_btn_plus(i_btn_plus),
    .o_vol(o_vol), .o_wr_req(o_wr_req), .o_wr_data(o_wr_data), .i_wr_ack(i_wr_ack),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // clock/reset block
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  // reference model: level, press episode (which button, cycles held), lock, write channel
  int         m_vol;
  int         m_held;   // 0 none, 1 minus, 2 plus
  int         m_n;
  bit         m_locked;
  bit         m_pending;
  bit         m_req;
  logic [7:0] m_data;

  logic [7:0] exp_q[$];
  logic       prev_req;
  int         req_rises;
  logic [7:0] last_rise_data;
  int         ack_mode;  // 0 never, 1 ack every request, 2 random (incl. stray acks)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vol = VDEF; m_held = 0; m_n = 0; m_locked = 0;
    m_pending = 1; m_req = 0; m_data = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit p, m, held_now, other;
    int dir, nv;
    bit changed;
    if (i_rst) begin
      model_reset();
      return;
    end
    p = !i_btn_plus;
    m = !i_btn_minus;
    dir = 0;
    if (m_locked) begin
      if (!p && !m) m_locked = 0;
    end else if (m_held == 0) begin
      if (p && m) m_locked = 1;
      else if (p) begin m_held = 2; m_n = 0; dir = 1; end
      else if (m) begin m_held = 1; m_n = 0; dir = -1; end
    end else begin
      held_now = (m_held == 2) ? p : m;
      other    = (m_held == 2) ? m : p;
      if (!held_now) m_held = 0;
      else if (other) begin m_locked = 1; m_held = 0; end
      else begin
        m_n++;
        // first step at press, next after HOLD cycles, then every REP cycles
        if (m_n == HOLD || (m_n > HOLD && (m_n - HOLD) % REP == 0))
          dir = (m_held == 2) ? 1 : -1;
      end
    end
    nv = m_vol + dir;
    if (nv > VMAX) nv = VMAX;
    if (nv < 0) nv = 0;
    changed = (nv != m_vol);
    if (m_req) begin
      if (i_wr_ack) m_req = 0;
      m_pending = m_pending | changed;
    end else if (m_pending) begin
      m_req = 1;
      m_data = 8'(m_vol);
      exp_q.push_back(m_data);
      m_pending = changed;
    end else begin
      m_pending = changed;
    end
    m_vol = nv;
  endtask

  task automatic check_outputs();
    logic [7:0] want;
    chk("vol", o_vol, m_vol);
    chk("wr_req", o_wr_req, m_req);
    if (m_req) chk("wr_data", o_wr_data, m_data);
    chk("busy", o_busy, m_req | m_pending);
    if (o_wr_req && !prev_req) begin
      req_rises++;
      last_rise_data = o_wr_data;
      if (exp_q.size() == 0) chk("sb_unexpected_req", 1, 0);
      else begin
        want = exp_q.pop_front();
        chk("sb_wr_data", o_wr_data, want);
      end
    end
    prev_req = o_wr_req;
  endtask

  // driver: one clock, model in lockstep, sample 1 time unit after the edge
  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    check_outputs();
    case (ack_mode)
      1:       i_wr_ack = m_req;
      2:       i_wr_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      default: i_wr_ack = 1'b0;
    endcase
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_plus(input int n);
    i_btn_plus = 1'b0; ticks(n); i_btn_plus = 1'b1;
  endtask

  task automatic pulse_minus(input int n);
    i_btn_minus = 1'b0; ticks(n); i_btn_minus = 1'b1;
  endtask

  initial begin
    int r0;
    i_rst = 1'b1; i_btn_minus = 1'b1; i_btn_plus = 1'b1; i_wr_ack = 1'b0;
    ack_mode = 0; req_rises = 0; prev_req = 1'b0; last_rise_data = 8'h00;
    model_reset();
    ticks(3);
    chk("rst_vol", o_vol, 8);
    chk("rst_req", o_wr_req, 0);
    chk("rst_data", o_wr_data, 8'h00);
    chk("rst_busy", o_busy, 1);

    // initial write, acked after three cycles
    i_rst = 1'b0;
    tick();
    chk("init_req", o_wr_req, 1);
    chk("init_data", o_wr_data, 8'h08);
    ticks(2);
    i_wr_ack = 1'b1;
    tick();
    i_wr_ack = 1'b0;
    chk("init_req_drop", o_wr_req, 0);
    chk("init_busy_low", o_busy, 0);

    // short plus press: one step, one write, no repeat
    ack_mode = 1;
    r0 = req_rises;
    i_btn_plus = 1'b0;
    tick();
    chk("plus_step", o_vol, 9);
    ticks(2);
    i_btn_plus = 1'b1;
    ticks(10);
    chk("plus_pulse_vol", o_vol, 9);
    chk("plus_pulse_reqs", req_rises - r0, 1);
    chk("plus_pulse_data", last_rise_data, 8'h09);

    // hold plus 30 cycles with acks withheld, then release and ack
    ack_mode = 0;
    r0 = req_rises;
    pulse_plus(30);
    chk("hold_vol", o_vol, 15);
    chk("hold_reqs_during", req_rises - r0, 1);
    ack_mode = 1;
    ticks(10);
    chk("hold_reqs_total", req_rises - r0, 2);
    chk("hold_last_data", last_rise_data, 8'h0F);

    // saturation at both ends
    r0 = req_rises;
    pulse_plus(2);
    ticks(5);
    chk("sat_top_vol", o_vol, 15);
    chk("sat_top_reqs", req_rises - r0, 0);
    pulse_minus(80);
    ticks(6);
    chk("ramp_down_vol", o_vol, 0);
    r0 = req_rises;
    pulse_minus(2);
    ticks(5);
    chk("sat_bot_vol", o_vol, 0);
    chk("sat_bot_reqs", req_rises - r0, 0);

    // lock: minus held, plus joins at cycle 5
    for (int k = 0; k < 3; k++) begin
      pulse_plus(1);
      ticks(2);
    end
    ticks(5);
    chk("lock_start_vol", o_vol, 3);
    i_btn_minus = 1'b0;
    ticks(5);
    i_btn_plus = 1'b0;
    tick();
    i_btn_plus = 1'b1;
    ticks(20);
    chk("lock_vol", o_vol, 2);
    i_btn_minus = 1'b1;
    ticks(3);
    chk("lock_release_vol", o_vol, 2);
    pulse_plus(1);
    chk("unlock_step", o_vol, 3);
    ticks(5);

    // random buttons and acks
    ack_mode = 2;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) i_btn_plus = ~i_btn_plus;
      if ($urandom_range(0, 15) == 0) i_btn_minus = ~i_btn_minus;
      tick();
    end
    i_btn_plus = 1'b1; i_btn_minus = 1'b1;
    ack_mode = 1;
    ticks(20);

    // asynchronous reset while a request is outstanding
    ack_mode = 0;
    if (o_vol == 4'd15) pulse_minus(1); else pulse_plus(1);
    for (int k = 0; k < 20 && !o_wr_req; k++) tick();
    chk("pre_rst_req", o_wr_req, 1);
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("async_rst_req", o_wr_req, 0);
    chk("async_rst_vol", o_vol, 8);
    tick();
    i_rst = 1'b0;
    tick();
    chk("post_rst_req", o_wr_req, 1);
    chk("post_rst_data", o_wr_data, 8'h08);
    ack_mode = 1;
    ticks(5);
    chk("sb_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
